// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple adder with carry in/out; one nibble of the
// serial datapath.
module adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] full;

    // Five-bit sum keeps the carry out alongside the nibble result.
    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        s    = full[3:0];
        cout = full[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: operands are accepted on a valid/ready handshake,
// then added one nibble per cycle (LSB first) through a single adder_4bit,
// with the carry held in a register between cycles.
// Optional macro NSA_SUBTRACT_EN adds op_sub (a - b) and ovf_signed.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NUM_NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_a,
    input  logic [NIBBLE_W*NUM_NIBBLES-1:0] op_b,
    input  logic                          carry_in,
`ifdef NSA_SUBTRACT_EN
    input  logic                          op_sub,
    output logic                          ovf_signed,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NIBBLE_W*NUM_NIBBLES-1:0] sum,
    output logic                          carry_out
);

    localparam int W     = NIBBLE_W * NUM_NIBBLES;
    localparam int CNT_W = $clog2(NUM_NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_NIBBLES - 1);

    nsa_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     a_reg, b_reg, sum_reg;
    logic             c_reg;
    logic [W-1:0]     b_in;
    logic             c_in;
    logic             accept;
    logic [3:0]       nib_sum;
    logic             nib_cout;

    assign accept = (state == IDLE) && in_valid;

`ifdef NSA_SUBTRACT_EN
    logic a_msb, b_msb;

    // Subtraction is a + ~b + 1; the inversion is folded in at accept time.
    assign b_in = op_sub ? ~op_b : op_b;
    assign c_in = op_sub ? 1'b1 : carry_in;

    // Two's-complement overflow: operands agree in sign, result does not.
    assign ovf_signed = (a_msb == b_msb) && (sum_reg[W-1] != a_msb);

    // Operand sign bits captured at accept for the overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
        end else if (accept) begin
            a_msb <= op_a[W-1];
            b_msb <= b_in[W-1];
        end
    end
`else
    assign b_in = op_b;
    assign c_in = carry_in;
`endif

    adder_4bit u_adder (
        .a    (a_reg[NIBBLE_W-1:0]),
        .b    (b_reg[NIBBLE_W-1:0]),
        .cin  (c_reg),
        .s    (nib_sum),
        .cout (nib_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand shift registers, carry, nibble counter and result accumulator.
    // The result shifts in from the top, so after the last nibble sum_reg
    // holds the full sum and stays put through DONE and IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            c_reg   <= 1'b0;
            cnt     <= '0;
            sum_reg <= '0;
        end else if (accept) begin
            a_reg <= op_a;
            b_reg <= b_in;
            c_reg <= c_in;
            cnt   <= '0;
        end else if (state == ADD) begin
            sum_reg <= {nib_sum, sum_reg[W-1:NIBBLE_W]};
            c_reg   <= nib_cout;
            a_reg   <= {{NIBBLE_W{1'b0}}, a_reg[W-1:NIBBLE_W]};
            b_reg   <= {{NIBBLE_W{1'b0}}, b_reg[W-1:NIBBLE_W]};
            cnt     <= cnt + CNT_W'(1);
        end
    end

    assign sum       = sum_reg;
    assign carry_out = c_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (NUM_NIBBLES=4, 16-bit operands).
module tb_nibble_serial_adder;

    localparam int NN = 4;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         carry_out;
`ifdef NSA_SUBTRACT_EN
    logic         op_sub = 1'b0;
    logic         ovf_signed;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;
    exp_t sb[$];

    nibble_serial_adder #(.NUM_NIBBLES(NN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .carry_in  (carry_in),
`ifdef NSA_SUBTRACT_EN
        .op_sub    (op_sub),
        .ovf_signed(ovf_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted result is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum %h with nothing expected", sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result_sum", sum, e.s);
                check("result_carry", {15'd0, carry_out}, {15'd0, e.c});
`ifdef NSA_SUBTRACT_EN
                check("result_ovf", {15'd0, ovf_signed}, {15'd0, e.o});
`endif
            end
        end
    end

    // Present operands, complete the handshake, queue the expectation and
    // verify that out_valid rises exactly NN edges after the handshake.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        exp_t e;
        op_a = a;
        op_b = b;
        carry_in = cin;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        e.s = es;
        e.c = ec;
        e.o = eo;
        sb.push_back(e);
        for (int i = 0; i < NN; i++) begin
            check("latency_early", {15'd0, out_valid}, 16'd0);
            tick();
        end
        check("latency_valid", {15'd0, out_valid}, 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset raised between clock edges.
        #2 rst = 1'b1;
        #1;
        check("reset_in_ready", {15'd0, in_ready}, 16'd1);
        check("reset_out_valid", {15'd0, out_valid}, 16'd0);
        check("reset_sum", sum, 16'h0000);
        check("reset_carry", {15'd0, carry_out}, 16'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic addition and return to IDLE.
        out_ready = 1'b1;
        issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        tick();
        check("idle_in_ready", {15'd0, in_ready}, 16'd1);
        check("idle_out_valid", {15'd0, out_valid}, 16'd0);

        // Full carry ripple, and carry_in feeding nibble 0.
        issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        issue(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);
        tick();

        // Backpressure: result held, new operands ignored.
        out_ready = 1'b0;
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_a = ~op_a;
            op_b = op_b ^ 16'h5A5A;
            carry_in = ~carry_in;
            tick();
            check("hold_out_valid", {15'd0, out_valid}, 16'd1);
            check("hold_sum", sum, 16'h3333);
            check("hold_carry", {15'd0, carry_out}, 16'd0);
            check("hold_in_ready", {15'd0, in_ready}, 16'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("release_in_ready", {15'd0, in_ready}, 16'd1);
        check("release_out_valid", {15'd0, out_valid}, 16'd0);
        check("idle_sum_kept", sum, 16'h3333);
        issue(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        tick();

        // Reset during the second ADD cycle aborts the operation.
        op_a = 16'hAAAA;
        op_b = 16'h5555;
        carry_in = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("abort_in_ready", {15'd0, in_ready}, 16'd1);
        check("abort_out_valid", {15'd0, out_valid}, 16'd0);
        check("abort_sum", sum, 16'h0000);
        check("abort_carry", {15'd0, carry_out}, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("abort_no_valid", {15'd0, out_valid}, 16'd0);
            tick();
        end
        issue(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        tick();

`ifdef NSA_SUBTRACT_EN
        // Subtraction; carry_in is ignored when op_sub is set.
        op_sub = 1'b1;
        issue(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        tick();
        issue(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1);
        tick();
        op_sub = 1'b0;
`endif

        tick();
        check("scoreboard_drained", 16'(sb.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
